// File: rtl/psm_deadtime_mc.sv
// psm_deadtime_mc: multi-channel complementary gate-pair generator with
// double-buffered rise/fall dead times, short-pulse suppression and fault latch.
module psm_deadtime_mc #(
    parameter int N_CH      = 3,
    parameter int BITS_DATA = 7
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 iEN,
    input  logic                 iFAULT,
    input  logic                 iCLR_FAULT,
    input  logic                 iLOAD,
    input  logic [BITS_DATA:0]   iDT_RISE,
    input  logic [BITS_DATA:0]   iDT_FALL,
    input  logic [N_CH-1:0]      iPSM,
    output logic [2*N_CH-1:0]    oPSM,
    output logic                 oFAULT,
    output logic                 oLOAD_PEND
);
    typedef enum logic [2:0] {OFF, LOW, DEAD_H, HIGH, DEAD_L} state_t;

    localparam logic [BITS_DATA:0] ONE = {{BITS_DATA{1'b0}}, 1'b1};

    state_t             state [N_CH];
    logic [BITS_DATA:0] cnt   [N_CH];
    logic [N_CH-1:0]    psm_r;
    logic [BITS_DATA:0] act_rise, act_fall, sh_rise, sh_fall;
    logic [BITS_DATA:0] rise_eff, fall_eff;
    logic               in_dead, apply, halt;

    // Shadow values take effect on an edge with no dead interval running,
    // so every interval uses one value from its first edge to its last.
    always_comb begin
        in_dead = 1'b0;
        for (int k = 0; k < N_CH; k++)
            if (state[k] == DEAD_H || state[k] == DEAD_L)
                in_dead = 1'b1;
        apply    = oLOAD_PEND && !in_dead;
        rise_eff = apply ? sh_rise : act_rise;
        fall_eff = apply ? sh_fall : act_fall;
        halt     = iFAULT || oFAULT || !iEN;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            psm_r      <= '0;
            oFAULT     <= 1'b0;
            oLOAD_PEND <= 1'b0;
            act_rise   <= '1;
            act_fall   <= '1;
            sh_rise    <= '1;
            sh_fall    <= '1;
        end else begin
            psm_r <= iPSM;
            if (iFAULT)
                oFAULT <= 1'b1;
            else if (iCLR_FAULT)
                oFAULT <= 1'b0;
            if (apply) begin
                act_rise   <= sh_rise;
                act_fall   <= sh_fall;
                oLOAD_PEND <= 1'b0;
            end
            if (iLOAD && !iFAULT) begin
                sh_rise    <= iDT_RISE;
                sh_fall    <= iDT_FALL;
                oLOAD_PEND <= 1'b1;
            end
        end
    end

    // Gate pair per channel: oPSM[2k+1:2k] = {L, H}
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            oPSM <= '0;
            for (int k = 0; k < N_CH; k++) begin
                state[k] <= OFF;
                cnt[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (halt) begin
                    state[k]       <= OFF;
                    cnt[k]         <= '0;
                    oPSM[2*k +: 2] <= 2'b00;
                end else begin
                    unique case (state[k])
                        OFF: begin
                            state[k]       <= psm_r[k] ? HIGH : LOW;
                            oPSM[2*k +: 2] <= psm_r[k] ? 2'b01 : 2'b10;
                        end
                        LOW: begin
                            if (psm_r[k]) begin
                                if (rise_eff == '0) begin
                                    state[k]       <= HIGH;
                                    oPSM[2*k +: 2] <= 2'b01;
                                end else begin
                                    state[k]       <= DEAD_H;
                                    cnt[k]         <= ONE;
                                    oPSM[2*k +: 2] <= 2'b00;
                                end
                            end
                        end
                        DEAD_H: begin
                            if (!psm_r[k]) begin
                                state[k]       <= LOW;
                                oPSM[2*k +: 2] <= 2'b10;
                            end else if (cnt[k] >= rise_eff) begin
                                state[k]       <= HIGH;
                                oPSM[2*k +: 2] <= 2'b01;
                            end else begin
                                cnt[k] <= cnt[k] + ONE;
                            end
                        end
                        HIGH: begin
                            if (!psm_r[k]) begin
                                if (fall_eff == '0) begin
                                    state[k]       <= LOW;
                                    oPSM[2*k +: 2] <= 2'b10;
                                end else begin
                                    state[k]       <= DEAD_L;
                                    cnt[k]         <= ONE;
                                    oPSM[2*k +: 2] <= 2'b00;
                                end
                            end
                        end
                        DEAD_L: begin
                            if (psm_r[k]) begin
                                state[k]       <= HIGH;
                                oPSM[2*k +: 2] <= 2'b01;
                            end else if (cnt[k] >= fall_eff) begin
                                state[k]       <= LOW;
                                oPSM[2*k +: 2] <= 2'b10;
                            end else begin
                                cnt[k] <= cnt[k] + ONE;
                            end
                        end
                        default: begin
                            state[k]       <= OFF;
                            oPSM[2*k +: 2] <= 2'b00;
                        end
                    endcase
                end
            end
        end
    end
endmodule
